// File: rtl/feistel_decrypt.sv
// Iterative 5-round Feistel decryption: one shared F unit, round keys applied K4..K0.
// Accepts one block at a time (tready_o low while busy); F stalls longer than F_TIMEOUT abort with err_o.

module feistel_f #(
   parameter int HALF       = 128,
   parameter int KEY_SIZE   = 128,
   parameter int SBOX_WIDTH = 8,
   parameter int F_LAT      = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [SBOX_WIDTH-1:0] sbox_out_i,
   input  logic                  sbox_valid_i,
   input  logic                  f_tvalid_i,
   input  logic [HALF-1:0]       f_state_i,
   input  logic [KEY_SIZE-1:0]   f_key_i,
   output logic                  f_valid_o,
   output logic [HALF-1:0]       f_state_o
);
   localparam int CW = $clog2(F_LAT + 1);
   localparam logic [CW-1:0] CNT_START = CW'(F_LAT - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(1);

   logic [HALF-1:0] mix;
   logic [HALF-1:0] res_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            f_valid_q;

   // Mix: byte rotate of state^key, whitened with the S-box byte seen at issue.
   always_comb begin
      mix = f_state_i ^ f_key_i;
      mix = {mix[HALF-SBOX_WIDTH-1:0], mix[HALF-1:HALF-SBOX_WIDTH]} ^ {(HALF/SBOX_WIDTH){sbox_out_i}};
   end

   // The pipeline only advances while the S-box stream is valid; a new request restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         f_valid_q <= 1'b0;
      end else begin
         f_valid_q <= 1'b0;
         if (f_tvalid_i) begin
            res_q  <= mix;
            cnt_q  <= CNT_START;
            busy_q <= 1'b1;
         end else if (busy_q && sbox_valid_i) begin
            if (cnt_q == CNT_LAST) begin
               f_valid_q <= 1'b1;
               busy_q    <= 1'b0;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

   assign f_valid_o = f_valid_q;
   assign f_state_o = res_q;
endmodule

module feistel_decrypt #(
   parameter int ROUND      = 5,
   parameter int F_LAT      = 6,
   parameter int F_TIMEOUT  = 64,
   parameter int SBOX_WIDTH = 8,
   parameter int KEY_SIZE   = 128,
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [SBOX_WIDTH-1:0] sbox_out_i,
   input  logic                  sbox_valid_i,
   input  logic [KEY_SIZE-1:0]   k0_i,
   input  logic [KEY_SIZE-1:0]   k1_i,
   input  logic [KEY_SIZE-1:0]   k2_i,
   input  logic [KEY_SIZE-1:0]   k3_i,
   input  logic [KEY_SIZE-1:0]   k4_i,
   input  logic                  tvalid_i,
   output logic                  tready_o,
   input  logic [DATA_WIDTH-1:0] ciphertext_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] plaintext_o,
   output logic                  err_o
);
   localparam int HALF = DATA_WIDTH / 2;
   localparam int WDW  = $clog2(F_TIMEOUT + 1);
   localparam logic [2:0]     LAST_RND  = 3'(ROUND - 1);
   localparam logic [WDW-1:0] WDOG_LAST = WDW'(F_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                state_q;
   logic [HALF-1:0]       l_q, r_q;
   logic [KEY_SIZE-1:0]   key_q [ROUND];
   logic [2:0]            rnd_q;
   logic [WDW-1:0]        wdog_q;
   logic                  tready_q, valid_q, err_q;
   logic [DATA_WIDTH-1:0] plaintext_q;
   logic                  f_tvalid_q;
   logic [HALF-1:0]       f_state_q;
   logic [KEY_SIZE-1:0]   f_key_q;
   logic                  f_valid;
   logic [HALF-1:0]       f_state_out;

   feistel_f #(
      .HALF       (HALF),
      .KEY_SIZE   (KEY_SIZE),
      .SBOX_WIDTH (SBOX_WIDTH),
      .F_LAT      (F_LAT)
   ) u_f (
      .clk          (clk),
      .reset_n      (reset_n),
      .sbox_out_i   (sbox_out_i),
      .sbox_valid_i (sbox_valid_i),
      .f_tvalid_i   (f_tvalid_q),
      .f_state_i    (f_state_q),
      .f_key_i      (f_key_q),
      .f_valid_o    (f_valid),
      .f_state_o    (f_state_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         l_q         <= '0;
         r_q         <= '0;
         for (int i = 0; i < ROUND; i++) key_q[i] <= '0;
         rnd_q       <= '0;
         wdog_q      <= '0;
         tready_q    <= 1'b1;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         plaintext_q <= '0;
         f_tvalid_q  <= 1'b0;
         f_state_q   <= '0;
         f_key_q     <= '0;
      end else begin
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         f_tvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tvalid_i) begin
                  l_q      <= ciphertext_i[DATA_WIDTH-1:HALF];
                  r_q      <= ciphertext_i[HALF-1:0];
                  key_q[0] <= k0_i;
                  key_q[1] <= k1_i;
                  key_q[2] <= k2_i;
                  key_q[3] <= k3_i;
                  key_q[4] <= k4_i;
                  rnd_q    <= '0;
                  tready_q <= 1'b0;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               f_tvalid_q <= 1'b1;
               f_state_q  <= l_q;
               f_key_q    <= key_q[LAST_RND - rnd_q];
               wdog_q     <= '0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               wdog_q <= wdog_q + 1'b1;
               // Inverse round: L' = R ^ F(L,K), R' = L.
               if (f_valid) begin
                  l_q     <= r_q ^ f_state_out;
                  r_q     <= l_q;
                  rnd_q   <= rnd_q + 1'b1;
                  state_q <= (rnd_q == LAST_RND) ? S_DONE : S_ISSUE;
               end else if (wdog_q == WDOG_LAST) begin
                  err_q    <= 1'b1;
                  tready_q <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            S_DONE: begin
               valid_q     <= 1'b1;
               plaintext_q <= {l_q, r_q};
               tready_q    <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tready_o    = tready_q;
   assign valid_o     = valid_q;
   assign err_o       = err_q;
   assign plaintext_o = plaintext_q;
endmodule

// File: tb/tb_feistel_decrypt.sv
// Bench for feistel_decrypt: scoreboard queue filled at accept, drained by an output monitor.

module tb_feistel_decrypt;
   logic         clk = 1'b0;
   logic         reset_n;
   logic [7:0]   sbox_out;
   logic         sbox_valid;
   logic [127:0] key_v [5];
   logic         tvalid, tready, valid, err;
   logic [255:0] ct, pt;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      bit           is_err;
      logic [255:0] pt;
      int           acc;
   } exp_t;

   exp_t sbq [$];
   exp_t mon_e;

   localparam logic [255:0] PT0 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
   localparam logic [127:0] ONES = {128{1'b1}};

   feistel_decrypt dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sbox_out_i   (sbox_out),
      .sbox_valid_i (sbox_valid),
      .k0_i         (key_v[0]),
      .k1_i         (key_v[1]),
      .k2_i         (key_v[2]),
      .k3_i         (key_v[3]),
      .k4_i         (key_v[4]),
      .tvalid_i     (tvalid),
      .tready_o     (tready),
      .ciphertext_i (ct),
      .valid_o      (valid),
      .plaintext_o  (pt),
      .err_o        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_chk++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] fmod(input logic [127:0] s, input logic [127:0] k, input logic [7:0] sb);
      logic [127:0] t;
      t = s ^ k;
      return {t[119:0], t[127:120]} ^ {16{sb}};
   endfunction

   // Forward cipher with K0 first: L' = R, R' = L ^ F(R,K).
   function automatic logic [255:0] enc(input logic [255:0] p, input logic [7:0] sb);
      logic [127:0] l, r, t;
      l = p[255:128];
      r = p[127:0];
      for (int i = 0; i < 5; i++) begin
         t = r;
         r = l ^ fmod(r, key_v[i], sb);
         l = t;
      end
      return {l, r};
   endfunction

   task automatic randomize_keys();
      for (int i = 0; i < 5; i++) key_v[i] = rnd128();
   endtask

   task automatic send(input logic [255:0] c, input logic [255:0] exp_pt, input bit is_err, output int acc);
      exp_t e;
      acc    = -1;
      tvalid = 1'b1;
      ct     = c;
      for (int i = 0; i < 200 && !tready; i++) @(negedge clk);
      if (!tready) begin
         note_fail("accept_timeout");
         tvalid = 1'b0;
         return;
      end
      acc      = cyc + 1;
      e.is_err = is_err;
      e.pt     = exp_pt;
      e.acc    = acc;
      sbq.push_back(e);
      @(negedge clk);
      tvalid = 1'b0;
      ct     = ~c;
      randomize_keys();
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         note_fail("drain_timeout");
         sbq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && (valid || err)) begin
            if (sbq.size() == 0) begin
               note_fail("unexpected_output");
            end else begin
               mon_e = sbq.pop_front();
               check("kind_err", {255'b0, err}, {255'b0, mon_e.is_err});
               if (!mon_e.is_err) check("plaintext", pt, mon_e.pt);
               check("latency", 256'(cyc - mon_e.acc), mon_e.is_err ? 256'd65 : 256'd41);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc;
      int rdy_from;
      int n_acc;
      logic [255:0] p;
      reset_n    = 1'b0;
      tvalid     = 1'b0;
      ct         = '0;
      sbox_out   = 8'h00;
      sbox_valid = 1'b1;
      for (int i = 0; i < 5; i++) key_v[i] = '0;
      repeat (2) @(negedge clk);
      check("reset_tready", {255'b0, tready}, 256'd1);
      check("reset_valid", {255'b0, valid}, 256'd0);
      check("reset_err", {255'b0, err}, 256'd0);
      check("reset_plaintext", pt, 256'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Hand vectors, zero keys: F(x) = rotl8(x) ^ sbox byte.
      send({ONES, ONES}, {ONES, 128'd0}, 1'b0, acc);
      for (int i = 0; i < 5; i++) key_v[i] = '0;
      drain();
      sbox_out = 8'hFF;
      send(256'd0, {128'd0, ONES}, 1'b0, acc);
      drain();

      // Loopback through the forward cipher with random keys.
      sbox_out = 8'h5A;
      randomize_keys();
      send(enc(PT0, 8'h5A), PT0, 1'b0, acc);
      drain();
      sbox_out = 8'hC3;
      randomize_keys();
      p = {rnd128(), rnd128()};
      send(enc(p, 8'hC3), p, 1'b0, acc);
      drain();

      // F stalled by an invalid S-box stream: watchdog abort, then recovery.
      sbox_valid = 1'b0;
      send({rnd128(), rnd128()}, 256'd0, 1'b1, acc);
      drain();
      check("tready_after_err", {255'b0, tready}, 256'd1);
      sbox_valid = 1'b1;
      repeat (10) @(negedge clk);
      sbox_out = 8'h17;
      randomize_keys();
      send(enc(~PT0, 8'h17), ~PT0, 1'b0, acc);
      drain();

      // tvalid held with a new ciphertext every cycle.
      sbox_out = 8'h3C;
      randomize_keys();
      rdy_from = 0;
      n_acc    = 0;
      tvalid   = 1'b1;
      for (int i = 0; i < 100; i++) begin
         p  = {8{32'(32'h1000_0000 + i)}};
         ct = enc(p, 8'h3C);
         check("tready_stream", {255'b0, tready}, {255'b0, (cyc >= rdy_from)});
         if (tready) begin
            mon_e.is_err = 1'b0;
            mon_e.pt     = p;
            mon_e.acc    = cyc + 1;
            sbq.push_back(mon_e);
            rdy_from = cyc + 1 + 41;
            n_acc++;
         end
         @(negedge clk);
      end
      tvalid = 1'b0;
      check("stream_accepts", 256'(n_acc), 256'd3);
      drain();

      // Reset during round 3.
      sbox_out = 8'h81;
      randomize_keys();
      p = {rnd128(), rnd128()};
      send(enc(p, 8'h81), p, 1'b0, acc);
      repeat (19) @(negedge clk);
      reset_n = 1'b0;
      sbq.delete();
      #1;
      check("midreset_tready", {255'b0, tready}, 256'd1);
      check("midreset_valid", {255'b0, valid}, 256'd0);
      check("midreset_err", {255'b0, err}, 256'd0);
      check("midreset_plaintext", pt, 256'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (60) @(negedge clk);
      randomize_keys();
      p = {rnd128(), rnd128()};
      send(enc(p, 8'h81), p, 1'b0, acc);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
